mod_exp_seq: RTL and testbench

MOD_EXP_SEQ -- requirements
Module: mod_exp_seq

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/mod_exp_seq_if.sv | 31 +++
 rtl/mod_exp_seq.sv | 150 +++++++++++++++
 tb/tb_mod_exp_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and default widths for the sequential modular exponentiator.
// The FSM state enum lives here so the core and any checkers agree on it.
package rsa_pkg;

  localparam int NUM_WIDTH_DEF = 12;
  localparam int N_WIDTH_DEF   = 6;
  localparam int E_WIDTH_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RED_ISS  = 3'd1,
    RED_WAIT = 3'd2,
    SQ_ISS   = 3'd3,
    SQ_WAIT  = 3'd4,
    MUL_ISS  = 3'd5,
    MUL_WAIT = 3'd6,
    DONE     = 3'd7
  } state_e;

endpackage

// File: rtl/mod_exp_seq_if.sv
// Request/response and modulo-table bus of mod_exp_seq.
// The master side drives operands and hosts the shared lookup table.
interface mod_exp_seq_if #(
  parameter int num_width = 12,
  parameter int N_width   = 6,
  parameter int E_width   = 8
) ();

  logic                 start;
  logic [num_width-1:0] base;
  logic [E_width-1:0]   exp;
  logic [N_width-1:0]   N;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [N_width-1:0]   result;
  logic [num_width-1:0] lut_num;
  logic [N_width-1:0]   lut_N;
  logic [N_width-1:0]   lut_out;

  modport master (
    output start, base, exp, N, lut_out,
    input  busy, done, err, result, lut_num, lut_N
  );

  modport slave (
    input  start, base, exp, N, lut_out,
    output busy, done, err, result, lut_num, lut_N
  );

endinterface

// File: rtl/mod_exp_seq.sv
// Left-to-right square-and-multiply base^exp mod N using an external
// registered modulo table; every reduction is one issue cycle plus one wait cycle.
module mod_exp_seq
  import rsa_pkg::*;
#(
  parameter int num_width = NUM_WIDTH_DEF,
  parameter int N_width   = N_WIDTH_DEF,
  parameter int E_width   = E_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mod_exp_seq_if.slave  bus
);

  localparam int IW = (E_width > 1) ? $clog2(E_width) : 1;

  state_e               state_q,   state_d;
  logic [num_width-1:0] base_q,    base_d;
  logic [E_width-1:0]   exp_q,     exp_d;
  logic [N_width-1:0]   n_q,       n_d;
  logic [N_width-1:0]   r_q,       r_d;
  logic [N_width-1:0]   b_q,       b_d;
  logic [IW-1:0]        i_q,       i_d;
  logic [num_width-1:0] lut_num_q, lut_num_d;
  logic [N_width-1:0]   result_q,  result_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
  logic                 err_q,     err_d;

  // Next-state and next-output computation for the exponentiation sequence
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    exp_d     = exp_q;
    n_d       = n_q;
    r_d       = r_q;
    b_d       = b_q;
    i_d       = i_q;
    result_d  = result_q;
    err_d     = 1'b0;
    lut_num_d = {num_width{1'b0}};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d = bus.base;
          exp_d  = bus.exp;
          n_d    = bus.N;
          r_d    = N_width'(1);
          i_d    = IW'(E_width - 1);
          if (bus.N < N_width'(2)) begin
            // A modulus below 2 has no meaningful residue: report and finish.
            r_d     = {N_width{1'b0}};
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RED_ISS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RED_ISS:  state_d = RED_WAIT;
      RED_WAIT: begin
        b_d     = bus.lut_out;
        state_d = SQ_ISS;
      end
      SQ_ISS:   state_d = SQ_WAIT;
      SQ_WAIT: begin
        r_d = bus.lut_out;
        if (exp_q[i_q]) begin
          state_d = MUL_ISS;
        end else if (i_q == IW'(0)) begin
          state_d = DONE;
        end else begin
          i_d     = i_q - IW'(1);
          state_d = SQ_ISS;
        end
      end
      MUL_ISS:  state_d = MUL_WAIT;
      MUL_WAIT: begin
        r_d = bus.lut_out;
        if (i_q == IW'(0)) begin
          state_d = DONE;
        end else begin
          i_d     = i_q - IW'(1);
          state_d = SQ_ISS;
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Table dividend is registered, so it is derived from the state being entered.
    case (state_d)
      RED_ISS: lut_num_d = base_d;
      SQ_ISS:  lut_num_d = num_width'({{N_width{1'b0}}, r_d} * {{N_width{1'b0}}, r_d});
      MUL_ISS: lut_num_d = num_width'({{N_width{1'b0}}, r_d} * {{N_width{1'b0}}, b_d});
      default: lut_num_d = {num_width{1'b0}};
    endcase

    if ((state_d == DONE) && (state_q != DONE)) begin
      result_d = r_d;
    end else begin
      result_d = result_q;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= {num_width{1'b0}};
      exp_q     <= {E_width{1'b0}};
      n_q       <= {N_width{1'b0}};
      r_q       <= {N_width{1'b0}};
      b_q       <= {N_width{1'b0}};
      i_q       <= {IW{1'b0}};
      lut_num_q <= {num_width{1'b0}};
      result_q  <= {N_width{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      exp_q     <= exp_d;
      n_q       <= n_d;
      r_q       <= r_d;
      b_q       <= b_d;
      i_q       <= i_d;
      lut_num_q <= lut_num_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.result  = result_q;
  assign bus.lut_num = lut_num_q;
  assign bus.lut_N   = n_q;

endmodule

// File: tb/tb_mod_exp_seq.sv
// Randomized and directed bench for mod_exp_seq: hosts the modulo table and
// checks every cycle against a transaction-level reference of base^exp mod N.
module tb_mod_exp_seq;
  import rsa_pkg::*;

  localparam int NW = 12;
  localparam int MW = 6;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   armed = 1'b0;

  mod_exp_seq_if #(.num_width(NW), .N_width(MW), .E_width(EW)) bus ();

  mod_exp_seq #(.num_width(NW), .N_width(MW), .E_width(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Shared modulo table with one-cycle registered read
  always @(posedge clk) begin
    if (bus.lut_N == '0) bus.lut_out <= '0;
    else                 bus.lut_out <= MW'(bus.lut_num % NW'(bus.lut_N));
  end

  function automatic int modpow(int b, int e, int n);
    longint r;
    if (n < 2) return 0;
    r = 1 % n;
    for (int k = 0; k < e; k++) r = (r * (b % n)) % n;
    return int'(r);
  endfunction

  function automatic int latency(int e, int n);
    if (n < 2) return 1;
    return 3 + 2 * EW + 2 * $countones(e[EW-1:0]);
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Transaction-level reference: one accepted job, a countdown, one done cycle
  bit m_active = 0, m_done = 0, m_err = 0, m_perr = 0;
  int m_cnt = 0, m_lat = 0, m_pend = 0, m_result = 0, m_n = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_active <= 0; m_done <= 0; m_err <= 0; m_cnt <= 0; m_result <= 0;
    end else if (m_done) begin
      m_done <= 0; m_err <= 0;
    end else if (m_active) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == m_lat) begin
        m_active <= 0; m_done <= 1; m_result <= m_pend; m_err <= m_perr;
      end
    end else if (bus.start) begin
      m_pend <= modpow(int'(bus.base), int'(bus.exp), int'(bus.N));
      m_perr <= (bus.N < 2);
      m_lat  <= latency(int'(bus.exp), int'(bus.N));
      m_n    <= int'(bus.N);
      m_cnt  <= 1;
      if (bus.N < 2) begin
        m_done <= 1; m_err <= 1; m_result <= 0;
      end else begin
        m_active <= 1;
      end
    end
  end

  // Every-cycle comparison against the reference, sampled on the falling edge
  always @(negedge clk) begin
    if (armed) begin
      chk("busy", bus.busy, m_active | m_done);
      chk("done", bus.done, m_done);
      chk("err", bus.err, m_err);
      chk("result", bus.result, m_result);
      if (!(m_active | m_done)) chk("lut_num_idle", bus.lut_num, 0);
      if (m_active) chk("lut_N", bus.lut_N, m_n);
    end
  end

  task automatic run_op(input int b, input int e, input int n,
                        input int req_res, input int req_cyc, input bit noisy);
    int cyc;
    int guard;
    guard = 0;
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("idle_timeout", guard, 0);
    bus.base  = NW'(b);
    bus.exp   = EW'(e);
    bus.N     = MW'(n);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 600) begin
      if (noisy) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.base  = NW'($urandom);
        bus.exp   = EW'($urandom);
        bus.N     = MW'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("done_cycle", cyc, req_cyc);
    chk("op_result", bus.result, req_res);
    chk("op_err", bus.err, (n < 2) ? 1 : 0);
  endtask

  initial begin
    int b, e, n;
    bus.start = 1'b0;
    bus.base  = '0;
    bus.exp   = '0;
    bus.N     = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_lut_num", bus.lut_num, 0);
    rst = 1'b0;
    armed = 1'b1;

    chk("model_8_3_55", modpow(8, 3, 55), 17);
    chk("model_17_27_55", modpow(17, 27, 55), 8);
    chk("model_lat_27", latency(27, 55), 27);

    run_op(8, 3, 55, 17, 23, 1'b0);
    run_op(17, 27, 55, 8, 27, 1'b1);
    run_op(2, 60, 61, 1, latency(60, 61), 1'b0);
    run_op(4095, 1, 63, 0, latency(1, 63), 1'b0);
    run_op(1234, 77, 1, 0, 1, 1'b0);
    run_op(99, 0, 33, 1, 19, 1'b0);

    // Reset while a job is in its first squaring wait cycle
    @(negedge clk);
    bus.base = 12'd8; bus.exp = 8'd3; bus.N = 6'd55; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    repeat (30) @(negedge clk);
    run_op(7, 3, 33, 13, 23, 1'b0);

    for (int k = 0; k < 40; k++) begin
      b = int'($urandom_range(0, 4095));
      e = int'($urandom_range(0, 255));
      n = int'($urandom_range(0, 63));
      run_op(b, e, n, modpow(b, e, n), latency(e, n), k[0]);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
